// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// default widths and the sequencer state type.
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RES_W_DEF  = 2 * DATA_W_DEF;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_DEC  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SHR  = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  // True for a divide whose divisor has already been found to be zero.
  function automatic logic is_div_zero(input logic [3:0] op, input logic b_is_zero);
    return (op == OP_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the combinational ALU: accept, hold operands for
// SETTLE_CYCLES, capture the result, return it. Optional divide-by-zero
// short-circuit is enabled by defining ALU_SEQ_DIVZERO_CHK_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RES_W         = 2 * DATA_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_en,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [3:0]        rsp_opcode,
  output logic              rsp_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              alu_en_q, alu_en_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_opcode_q, rsp_opcode_d;
  logic              rsp_err_q, rsp_err_d;
  logic              div_zero_s;

`ifdef ALU_SEQ_DIVZERO_CHK_EN
  assign div_zero_s = is_div_zero(cmd_opcode, (cmd_b == {DATA_W{1'b0}}));
`else
  assign div_zero_s = 1'b0;
`endif

  // Next-state and next-output logic; the ALU drive registers double as the
  // operand latch, so they are only loaded when an operation is issued.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_en_d     = alu_en_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (div_zero_s) begin
            state_d      = RESP;
            rsp_result_d = {RES_W{1'b0}};
            rsp_opcode_d = OP_DIV;
            rsp_err_d    = 1'b1;
          end else begin
            state_d  = ISSUE;
            cnt_d    = 4'd0;
            alu_en_d = 1'b1;
            alu_op_d = cmd_opcode;
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d      = RESP;
          cnt_d        = 4'd0;
          rsp_result_d = alu_result;
          rsp_opcode_d = alu_op_q;
          rsp_err_d    = 1'b0;
          alu_en_d     = 1'b0;
          alu_op_d     = 4'd0;
          alu_a_d      = {DATA_W{1'b0}};
          alu_b_d      = {DATA_W{1'b0}};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
        alu_en_d = 1'b0;
        alu_op_d = 4'd0;
        alu_a_d  = {DATA_W{1'b0}};
        alu_b_d  = {DATA_W{1'b0}};
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State, counter and all output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      cmd_ready_q  <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_op_q     <= 4'd0;
      alu_a_q      <= {DATA_W{1'b0}};
      alu_b_q      <= {DATA_W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {RES_W{1'b0}};
      rsp_opcode_q <= 4'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_en_q     <= alu_en_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_en     = alu_en_q;
  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and settle 3) each driving a
// behavioural ALU; responses of the settle-1 unit go through a scoreboard.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // settle-1 unit
  logic        c1_valid, c1_ready, a1_en, r1_valid, r1_ready, r1_err;
  logic [3:0]  c1_op, a1_op, r1_op;
  logic [15:0] c1_a, c1_b, a1_a, a1_b;
  logic [31:0] a1_res, r1_result;
  // settle-3 unit
  logic        c3_valid, c3_ready, a3_en, r3_valid, r3_ready, r3_err;
  logic [3:0]  c3_op, a3_op, r3_op;
  logic [15:0] c3_a, c3_b, a3_a, a3_b;
  logic [31:0] a3_res, r3_result;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea, eb;
    ea = {16'h0000, a};
    eb = {16'h0000, b};
    case (op)
      OP_ADD:  return ea + eb;
      OP_SUB:  return ea - eb;
      OP_MUL:  return ea * eb;
      OP_INC:  return ea + 32'd1;
      OP_DEC:  return ea - 32'd1;
      OP_PASS: return ea;
      OP_NOT:  return ~ea;
      OP_AND:  return ea & eb;
      OP_OR:   return ea | eb;
      OP_XOR:  return ea ^ eb;
      OP_XNOR: return ~(ea ^ eb);
      OP_NAND: return ~(ea & eb);
      OP_NOR:  return ~(ea | eb);
      OP_SHL:  return ea << 1;
      OP_SHR:  return ea >> 1;
      OP_DIV:  return (b == 16'h0000) ? 32'hFFFF_FFFF : ea / eb;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Garbage when disabled, so an out-of-window sample is visible.
  assign a1_res = a1_en ? alu_f(a1_op, a1_a, a1_b) : 32'hDEAD_BEEF;
  assign a3_res = a3_en ? alu_f(a3_op, a3_a, a3_b) : 32'hDEAD_BEEF;

  alu_cmd_sequencer #(.DATA_W(16), .RES_W(32), .SETTLE_CYCLES(1)) u_seq1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_opcode(c1_op), .cmd_a(c1_a), .cmd_b(c1_b),
    .alu_en(a1_en), .alu_opcode(a1_op), .alu_a(a1_a), .alu_b(a1_b), .alu_result(a1_res),
    .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_result(r1_result),
    .rsp_opcode(r1_op), .rsp_err(r1_err)
  );

  alu_cmd_sequencer #(.DATA_W(16), .RES_W(32), .SETTLE_CYCLES(3)) u_seq3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_opcode(c3_op), .cmd_a(c3_a), .cmd_b(c3_b),
    .alu_en(a3_en), .alu_opcode(a3_op), .alu_a(a3_a), .alu_b(a3_b), .alu_result(a3_res),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_result(r3_result),
    .rsp_opcode(r3_op), .rsp_err(r3_err)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] res, input logic err);
    exp_t e;
    e.op  = op;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: a response handshakes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && r1_valid && r1_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rsp", r1_result, 32'h0000_0000);
        if (r1_result === 32'h0000_0000) begin
          errors++;
          $error("FAIL sb_unexpected_rsp: observed response expected none");
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", r1_result, e.res);
        chk("sb_opcode", {28'h0, r1_op}, {28'h0, e.op});
        chk("sb_err", {31'h0, r1_err}, {31'h0, e.err});
      end
    end
  end

  initial begin
    int n;
    int t0;
    int t1;
    rst_n = 1'b0;
    c1_valid = 1'b0; c1_op = 4'd0; c1_a = 16'h0; c1_b = 16'h0; r1_ready = 1'b0;
    c3_valid = 1'b0; c3_op = 4'd0; c3_a = 16'h0; c3_b = 16'h0; r3_ready = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", {31'h0, c1_ready}, 32'd0);
    chk("rst_alu_en", {31'h0, a1_en}, 32'd0);
    chk("rst_rsp_valid", {31'h0, r1_valid}, 32'd0);
    chk("rst_rsp_result", r1_result, 32'd0);
    chk("rst_rsp_err", {31'h0, r1_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'h0, c1_ready}, 32'd1);

    // ADD 3+4, settle 1
    c1_valid = 1'b1; c1_op = OP_ADD; c1_a = 16'h0003; c1_b = 16'h0004; r1_ready = 1'b1;
    push(OP_ADD, 32'h0000_0007, 1'b0);
    tick();
    c1_valid = 1'b0;
    chk("add_en_c1", {31'h0, a1_en}, 32'd1);
    chk("add_a_c1", {16'h0, a1_a}, 32'h3);
    chk("add_b_c1", {16'h0, a1_b}, 32'h4);
    chk("add_ready_c1", {31'h0, c1_ready}, 32'd0);
    chk("add_rv_c1", {31'h0, r1_valid}, 32'd0);
    tick();
    chk("add_en_c2", {31'h0, a1_en}, 32'd0);
    chk("add_a_c2", {16'h0, a1_a}, 32'h0);
    chk("add_rv_c2", {31'h0, r1_valid}, 32'd1);
    tick();
    chk("add_rv_c3", {31'h0, r1_valid}, 32'd0);
    chk("add_ready_c3", {31'h0, c1_ready}, 32'd1);

    // MUL FFFF*FFFF, settle 3; operands changed after acceptance
    c3_valid = 1'b1; c3_op = OP_MUL; c3_a = 16'hFFFF; c3_b = 16'hFFFF;
    tick();
    c3_valid = 1'b0; c3_a = 16'h1234; c3_op = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      chk("mul_en", {31'h0, a3_en}, 32'd1);
      chk("mul_a", {16'h0, a3_a}, 32'h0000_FFFF);
      chk("mul_op", {28'h0, a3_op}, {28'h0, OP_MUL});
      chk("mul_rv", {31'h0, r3_valid}, 32'd0);
      tick();
    end
    chk("mul_en_off", {31'h0, a3_en}, 32'd0);
    chk("mul_rv", {31'h0, r3_valid}, 32'd1);
    chk("mul_result", r3_result, 32'hFFFE_0001);
    chk("mul_opcode", {28'h0, r3_op}, {28'h0, OP_MUL});
    tick();
    chk("mul_rv_drop", {31'h0, r3_valid}, 32'd0);

    // Backpressure: SHL 8001 held for five cycles
    r1_ready = 1'b0;
    c1_valid = 1'b1; c1_op = OP_SHL; c1_a = 16'h8001; c1_b = 16'h0001;
    push(OP_SHL, 32'h0001_0002, 1'b0);
    tick();
    c1_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", {31'h0, r1_valid}, 32'd1);
      chk("bp_result", r1_result, 32'h0001_0002);
      chk("bp_ready", {31'h0, c1_ready}, 32'd0);
      tick();
    end
    r1_ready = 1'b1;
    tick();
    chk("bp_release_rv", {31'h0, r1_valid}, 32'd0);
    chk("bp_release_ready", {31'h0, c1_ready}, 32'd1);

    // Back-to-back: SUB 10-3 then NOR 0,0 with cmd_valid held high
    t0 = cyc;
    c1_valid = 1'b1; c1_op = OP_SUB; c1_a = 16'd10; c1_b = 16'd3;
    push(OP_SUB, 32'h0000_0007, 1'b0);
    tick();
    c1_op = OP_NOR; c1_a = 16'h0000; c1_b = 16'h0000;
    push(OP_NOR, 32'hFFFF_FFFF, 1'b0);
    n = 0;
    while (c1_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    t1 = cyc;
    chk("b2b_ready", {31'h0, c1_ready}, 32'd1);
    chk("b2b_spacing", t1 - t0, 32'd3);
    tick();
    c1_valid = 1'b0;
    repeat (4) tick();

    // Reset in the second ISSUE cycle of the settle-3 unit
    c3_valid = 1'b1; c3_op = OP_ADD; c3_a = 16'h0001; c3_b = 16'h0001;
    tick();
    c3_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", {31'h0, a3_en}, 32'd0);
    chk("rst_mid_ready", {31'h0, c3_ready}, 32'd0);
    chk("rst_mid_rv", {31'h0, r3_valid}, 32'd0);
    chk("rst_mid_a", {16'h0, a3_a}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_rsp", {31'h0, r3_valid}, 32'd0);
    end
    c3_valid = 1'b1; c3_op = OP_XOR; c3_a = 16'hF0F0; c3_b = 16'h0FF0;
    n = 0;
    while (c3_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    c3_valid = 1'b0;
    n = 0;
    while (r3_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("post_rst_rv", {31'h0, r3_valid}, 32'd1);
    chk("post_rst_result", r3_result, 32'h0000_FF00);
    chk("post_rst_err", {31'h0, r3_err}, 32'd0);
    tick();

    // DIV by zero, then a legal DIV
    n = 0;
    while (c1_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("div_ready", {31'h0, c1_ready}, 32'd1);
    c1_valid = 1'b1; c1_op = OP_DIV; c1_a = 16'd100; c1_b = 16'd0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    push(OP_DIV, 32'h0000_0000, 1'b1);
`else
    push(OP_DIV, 32'hFFFF_FFFF, 1'b0);
`endif
    tick();
    c1_valid = 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    chk("div0_en", {31'h0, a1_en}, 32'd0);
    chk("div0_rv", {31'h0, r1_valid}, 32'd1);
`else
    chk("div0_en", {31'h0, a1_en}, 32'd1);
    chk("div0_rv", {31'h0, r1_valid}, 32'd0);
`endif
    tick();
    tick();
    c1_valid = 1'b1; c1_op = OP_DIV; c1_a = 16'd100; c1_b = 16'd7;
    push(OP_DIV, 32'd14, 1'b0);
    tick();
    c1_valid = 1'b0;
    repeat (3) tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
